// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle controller: opcode constants,
// FSM state encoding and ALUOp encodings.
package riscv_pkg;

  // Opcode field values of the supported instruction classes
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

  // ALUOp encodings seen by the ALU decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;  // address add for LW/SW
  localparam logic [1:0] ALUOP_BR   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNC = 2'b10;  // funct-field driven (R/I-type)

  // FSM states; the encoding is visible on state_o
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == R_TYPE) || (op == I_TYPE) || (op == LW) ||
           (op == SW) || (op == BR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready in a memory-wait
// state and flags a timeout on the last permitted cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,     // FSM is in a memory-wait state (FETCH/MEM)
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside wait states, so every entry into FETCH/MEM starts
  // from zero; a completed access also clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || mem_ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready on the last cycle still completes the access normally
  assign timeout_o = active_i && !mem_ready_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a memory-wait timeout that parks the FSM in ERR until reset.
//
// Handshake: a memory request is held (MemRead/MemWrite asserted) for as
// long as the FSM sits in FETCH or MEM; the access completes in the cycle
// where mem_ready=1, and the FSM advances on the following clock edge.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic [2:0] state_o,
  output logic       error
);

  state_t state_q;
  logic   wait_active;
  logic   timeout;

  assign wait_active = (state_q == FETCH) || (state_q == MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .active_i   (wait_active),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  // State register with next-state selection; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready)    state_q <= DECODE;
          else if (timeout) state_q <= ERR;
        end
        DECODE: state_q <= is_legal_op(Opcode) ? EXEC : ERR;
        EXEC: begin
          case (Opcode)
            R_TYPE, I_TYPE: state_q <= WB;
            LW, SW:         state_q <= MEM;
            BR:             state_q <= FETCH;
            default:        state_q <= ERR;
          endcase
        end
        MEM: begin
          if (mem_ready)    state_q <= (Opcode == LW) ? WB : FETCH;
          else if (timeout) state_q <= ERR;
        end
        WB:      state_q <= FETCH;
        ERR:     state_q <= ERR;
        default: state_q <= ERR;
      endcase
    end
  end

  // Control strobes decoded from state (plus mem_ready/br_taken where the
  // strobe must act in the same cycle). Reset forces every output low so an
  // in-flight memory access is dropped in the reset cycle itself.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    ALUOp    = ALUOP_ADD;
    error    = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        EXEC: begin
          case (Opcode)
            R_TYPE: ALUOp = ALUOP_FUNC;
            I_TYPE: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_FUNC;
            end
            LW, SW: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_ADD;
            end
            BR: begin
              Branch  = 1'b1;
              PCSrc   = 1'b1;
              PCWrite = br_taken;
              ALUOp   = ALUOP_BR;
            end
            default: ;
          endcase
        end
        MEM: begin
          IorD     = 1'b1;
          MemRead  = (Opcode == LW);
          MemWrite = (Opcode == SW);
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = (Opcode == LW);
        end
        ERR:     error = 1'b1;
        default: ;
      endcase
    end
  end

  // Debug view of the state; reads as FETCH while reset is held
  assign state_o = reset ? FETCH : state_q;

endmodule
